// File: rtl/i2c_arbiter.sv
// Two-port round-robin front end for a shared I2C master core: posts one request
// per port, hands it to the core via start/busy, and enforces the EEPROM write gap.
module i2c_arbiter #(
   parameter int START_TO    = 1000,
   parameter int XFER_TO     = 200000,
   parameter int WR_WAIT_CYC = 250000,
   parameter int TW          = 24
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [1:0]  req,
   input  logic [1:0]  req_rd,
   input  logic [1:0]  req_a16,
   input  logic [13:0] req_dev,
   input  logic [31:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic [1:0]  done,
   output logic [1:0]  err,
   output logic [7:0]  rdata,
   output logic        busy_o,
   output logic        core_start,
   output logic        core_high_addr,
   output logic [6:0]  core_dev_addr,
   output logic [15:0] core_mem_addr,
   output logic        core_rd_wr_en,
   output logic [7:0]  core_data_wr,
   input  logic [7:0]  core_data_rd,
   input  logic        core_busy,
   input  logic        core_nack
);

   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, COMPLETE, WR_WAIT} state_t;

   state_t         r_state;
   logic [1:0]     r_pending;
   logic           r_last;
   logic           r_g;
   logic [TW-1:0]  r_timer;
   logic [1:0]     r_rd;
   logic [1:0]     r_a16;
   logic [6:0]     r_dev   [2];
   logic [15:0]    r_addr  [2];
   logic [7:0]     r_wdata [2];

   logic [1:0]     w_clr;
   logic [1:0]     w_accept;
   logic           w_gnt;

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
      return (&t) ? t : t + 1'b1;
   endfunction

   // A request arriving in the completion cycle of its own port is taken.
   assign w_clr    = (r_state == COMPLETE) ? (2'b01 << r_g) : 2'b00;
   assign w_accept = req & (~r_pending | w_clr);
   assign w_gnt    = (r_pending == 2'b11) ? ~r_last : r_pending[1];
   assign busy_o   = (r_state != IDLE);

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (w_accept[i]) begin
            r_rd[i]    <= req_rd[i];
            r_a16[i]   <= req_a16[i];
            r_dev[i]   <= req_dev[7*i +: 7];
            r_addr[i]  <= req_addr[16*i +: 16];
            r_wdata[i] <= req_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state        <= IDLE;
         r_pending      <= '0;
         r_last         <= 1'b1;
         r_g            <= 1'b0;
         r_timer        <= '0;
         done           <= '0;
         err            <= '0;
         rdata          <= '0;
         core_start     <= 1'b0;
         core_high_addr <= 1'b0;
         core_dev_addr  <= '0;
         core_mem_addr  <= '0;
         core_rd_wr_en  <= 1'b0;
         core_data_wr   <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_accept;
         done      <= '0;
         err       <= '0;
         case (r_state)
            IDLE: begin
               if ((|r_pending) && !core_busy) begin
                  r_g            <= w_gnt;
                  r_last         <= w_gnt;
                  core_high_addr <= r_a16[w_gnt];
                  core_dev_addr  <= r_dev[w_gnt];
                  core_mem_addr  <= r_addr[w_gnt];
                  core_rd_wr_en  <= r_rd[w_gnt];
                  core_data_wr   <= r_wdata[w_gnt];
                  core_start     <= 1'b1;
                  r_timer        <= '0;
                  r_state        <= LAUNCH;
               end
            end
            // Start is held until busy is seen, since the core samples it slowly.
            LAUNCH: begin
               if (core_busy) begin
                  core_start <= 1'b0;
                  r_timer    <= '0;
                  r_state    <= RUN;
               end else if (r_timer == TW'(START_TO - 1)) begin
                  core_start <= 1'b0;
                  done[r_g]  <= 1'b1;
                  err[r_g]   <= 1'b1;
                  r_state    <= COMPLETE;
               end else begin
                  r_timer <= sat_inc(r_timer);
               end
            end
            RUN: begin
               if (!core_busy) begin
                  done[r_g] <= 1'b1;
                  err[r_g]  <= core_nack;
                  if (core_rd_wr_en && !core_nack)
                     rdata <= core_data_rd;
                  r_state <= COMPLETE;
               end else if (r_timer == TW'(XFER_TO - 1)) begin
                  done[r_g] <= 1'b1;
                  err[r_g]  <= 1'b1;
                  r_state   <= COMPLETE;
               end else begin
                  r_timer <= sat_inc(r_timer);
               end
            end
            COMPLETE: begin
               if (!core_rd_wr_en && !err[r_g]) begin
                  r_timer <= '0;
                  r_state <= WR_WAIT;
               end else begin
                  r_state <= IDLE;
               end
            end
            WR_WAIT: begin
               if (r_timer == TW'(WR_WAIT_CYC - 1))
                  r_state <= IDLE;
               else
                  r_timer <= sat_inc(r_timer);
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Randomized scoreboard bench for i2c_arbiter with a behavioural core model and
// a round-robin reference kept at the request level.
module tb_i2c_arbiter;
   localparam int START_TO    = 16;
   localparam int XFER_TO     = 100;
   localparam int WR_WAIT_CYC = 40;
   localparam int TW          = 12;

   typedef struct { bit rd; bit a16; logic [6:0] dev; logic [15:0] addr; logic [7:0] wd; int acc; } req_t;
   typedef struct { bit err; logic [7:0] data; int mode; } rsp_t;
   typedef struct { int mode; logic [7:0] data; } dir_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [1:0]  req = '0, req_rd = '0, req_a16 = '0;
   logic [13:0] req_dev = '0;
   logic [31:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  done, err;
   logic [7:0]  rdata;
   logic        busy_o, core_start, core_high_addr, core_rd_wr_en;
   logic [6:0]  core_dev_addr;
   logic [15:0] core_mem_addr;
   logic [7:0]  core_data_wr;
   logic [7:0]  core_data_rd = '0;
   logic        core_busy = 1'b0, core_nack = 1'b0;

   always #5 clk = ~clk;

   i2c_arbiter #(.START_TO(START_TO), .XFER_TO(XFER_TO), .WR_WAIT_CYC(WR_WAIT_CYC), .TW(TW)) dut (
      .clk(clk), .rstn(rstn), .req(req), .req_rd(req_rd), .req_a16(req_a16),
      .req_dev(req_dev), .req_addr(req_addr), .req_wdata(req_wdata),
      .done(done), .err(err), .rdata(rdata), .busy_o(busy_o), .core_start(core_start),
      .core_high_addr(core_high_addr), .core_dev_addr(core_dev_addr),
      .core_mem_addr(core_mem_addr), .core_rd_wr_en(core_rd_wr_en),
      .core_data_wr(core_data_wr), .core_data_rd(core_data_rd),
      .core_busy(core_busy), .core_nack(core_nack));

   int nchk = 0, nerr = 0, cyc = 0, nissue = 0, ndone = 0;
   req_t ent [2];
   bit   has [2];
   bit   launched [2];
   rsp_t resp_q [$];
   dir_t dir_q [$];
   int   glog [$];
   bit   m_last = 1'b1;
   logic [7:0] m_rdata = '0;
   int   infl = 0, launch_cyc = 0, drop_cyc = 0, wdone_cyc = 0, exp_launch_at = -1;
   bit   gap_arm = 1'b0, prev_start = 1'b0;
   int   cm_st = 0, cm_cnt = 0, cm_run = 0;
   bit   cm_nack = 1'b0;
   logic [7:0] cm_data = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_fields(input string pfx, input int g);
      chk({pfx, "_a16"},  32'(core_high_addr), 32'(ent[g].a16));
      chk({pfx, "_dev"},  32'(core_dev_addr),  32'(ent[g].dev));
      chk({pfx, "_addr"}, 32'(core_mem_addr),  32'(ent[g].addr));
      chk({pfx, "_rd"},   32'(core_rd_wr_en),  32'(ent[g].rd));
      chk({pfx, "_wd"},   32'(core_data_wr),   32'(ent[g].wd));
   endtask

   // Scoreboard monitor followed by the behavioural core model.
   always @(negedge clk) begin : mon
      bit e0, e1, lnow;
      int g;
      rsp_t r;
      dir_t d;
      if (!rstn) begin
         has[0] = 0; has[1] = 0; launched[0] = 0; launched[1] = 0;
         resp_q.delete();
         m_last = 1'b1; m_rdata = '0; gap_arm = 0; exp_launch_at = -1; prev_start = 0;
         cm_st = 0; core_busy = 0; core_nack = 0;
      end else begin
         lnow = 0;
         e0 = has[0] && !launched[0] && (ent[0].acc <= cyc - 1);
         e1 = has[1] && !launched[1] && (ent[1].acc <= cyc - 1);
         chk("err_without_done", 32'(err & ~done), 0);
         if (core_start && !prev_start) begin
            lnow = 1;
            chk("grant_while_core_busy", 32'(core_busy), 0);
            if (!e0 && !e1) begin
               chk("launch_has_request", 0, 1);
            end else begin
               g = (e0 && e1) ? (m_last ? 0 : 1) : (e1 ? 1 : 0);
               m_last = (g == 1);
               chk_fields("launch", g);
               launched[g] = 1; infl = g; launch_cyc = cyc;
               glog.push_back(g);
               if (gap_arm) chk("write_gap", 32'((cyc - wdone_cyc) >= WR_WAIT_CYC + 1), 1);
               gap_arm = 0;
            end
         end
         if (exp_launch_at == cyc) begin
            if (e0 || e1) chk("relaunch_2cyc", 32'(lnow), 1);
            exp_launch_at = -1;
         end
         if (done != 2'b00) begin
            chk("done_port", 32'(done), 32'(1) << infl);
            if (resp_q.size() == 0) begin
               chk("resp_available", 0, 1);
            end else begin
               r = resp_q.pop_front();
               chk("err", 32'(err[infl]), 32'(r.err));
               if (ent[infl].rd && !r.err) m_rdata = r.data;
               if (r.mode == 2) begin
                  chk("timeout_latency", cyc - launch_cyc, START_TO);
                  chk("timeout_start_low", 32'(core_start), 0);
               end else begin
                  chk("done_latency", cyc - drop_cyc, 1);
               end
               if (!ent[infl].rd && !r.err) begin
                  gap_arm = 1; wdone_cyc = cyc;
               end else begin
                  gap_arm = 0; exp_launch_at = cyc + 2;
               end
            end
            chk_fields("held", infl);
            has[infl] = 0; launched[infl] = 0; ndone++;
         end
         chk("rdata", 32'(rdata), 32'(m_rdata));

         case (cm_st)
            0: if (lnow) begin
                  if (dir_q.size() > 0) d = dir_q.pop_front();
                  else begin
                     g = $urandom_range(0, 99);
                     d.mode = (g < 70) ? 0 : (g < 85) ? 1 : 2;
                     d.data = 8'($urandom);
                  end
                  r.err = (d.mode == 1) || (d.mode == 2);
                  r.data = d.data; r.mode = d.mode;
                  resp_q.push_back(r);
                  if (d.mode != 2) begin
                     cm_nack = (d.mode == 1); cm_data = d.data;
                     cm_cnt = $urandom_range(0, 3);
                     cm_run = (d.mode == 3) ? 40 : $urandom_range(1, 6);
                     cm_st = 1;
                  end
               end
            1: if (cm_cnt == 0) begin
                  core_busy = 1; core_data_rd = 8'($urandom); cm_cnt = cm_run; cm_st = 2;
               end else cm_cnt--;
            2: if (cm_cnt == 0) begin
                  core_busy = 0; core_nack = cm_nack; core_data_rd = cm_data;
                  drop_cyc = cyc; cm_st = 0;
               end else cm_cnt--;
            default: cm_st = 0;
         endcase
         prev_start = core_start;
      end
   end

   task automatic tick();
      @(negedge clk);
      req = '0;
   endtask

   task automatic issue(input int p, input bit rd, input bit a16, input logic [6:0] dev,
                        input logic [15:0] addr, input logic [7:0] wd);
      req[p] = 1'b1; req_rd[p] = rd; req_a16[p] = a16;
      req_dev[7*p +: 7] = dev; req_addr[16*p +: 16] = addr; req_wdata[8*p +: 8] = wd;
      ent[p].rd = rd; ent[p].a16 = a16; ent[p].dev = dev; ent[p].addr = addr;
      ent[p].wd = wd; ent[p].acc = cyc + 1;
      launched[p] = 0; has[p] = 1; nissue++;
   endtask

   task automatic issue_rand(input int p);
      issue(p, 1'($urandom), 1'($urandom), 7'($urandom), 16'($urandom), 8'($urandom));
   endtask

   task automatic junk(input int p);
      req[p] = 1'b1; req_rd[p] = 1'($urandom); req_a16[p] = 1'($urandom);
      req_dev[7*p +: 7] = 7'($urandom); req_addr[16*p +: 16] = 16'($urandom);
      req_wdata[8*p +: 8] = 8'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((has[0] || has[1] || cm_st != 0 || busy_o) && n < budget) begin tick(); n++; end
      chk("wait_idle_in_budget", 32'(n < budget), 1);
   endtask

   task automatic wait_free(input int budget);
      int n = 0;
      while ((has[0] || has[1]) && n < budget) begin tick(); n++; end
      chk("wait_free_in_budget", 32'(n < budget), 1);
   endtask

   task automatic wait_done(input int p, input int budget);
      int n = 0;
      while (!done[p] && n < budget) begin tick(); n++; end
      chk("wait_done_in_budget", 32'(n < budget), 1);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_done"}, 32'(done), 0);
      chk({pfx, "_err"}, 32'(err), 0);
      chk({pfx, "_rdata"}, 32'(rdata), 0);
      chk({pfx, "_busy_o"}, 32'(busy_o), 0);
      chk({pfx, "_core_start"}, 32'(core_start), 0);
      chk({pfx, "_core_a16"}, 32'(core_high_addr), 0);
      chk({pfx, "_core_dev"}, 32'(core_dev_addr), 0);
      chk({pfx, "_core_addr"}, 32'(core_mem_addr), 0);
      chk({pfx, "_core_rd"}, 32'(core_rd_wr_en), 0);
      chk({pfx, "_core_wd"}, 32'(core_data_wr), 0);
   endtask

   initial begin
      int n;
      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      #2 rstn = 1'b1;
      tick(); tick();

      // Directed write on port 0, then read on port 1 right behind it.
      dir_q.push_back('{0, 8'h00});
      issue(0, 1'b0, 1'b1, 7'h50, 16'h0010, 8'hA5);
      tick(); chk("req2start_c1", 32'(core_start), 0);
      tick(); chk("req2start_c2", 32'(core_start), 1);
      chk("t1_dev", 32'(core_dev_addr), 32'h50);
      chk("t1_addr", 32'(core_mem_addr), 32'h0010);
      chk("t1_a16", 32'(core_high_addr), 1);
      chk("t1_rdwr", 32'(core_rd_wr_en), 0);
      chk("t1_wdata", 32'(core_data_wr), 32'hA5);
      wait_done(0, 100);
      chk("t1_err", 32'(err[0]), 0);
      dir_q.push_back('{0, 8'h3C});
      tick();
      issue(1, 1'b1, 1'b1, 7'h50, 16'h0010, 8'h00);
      wait_done(1, 200);
      chk("t2_err", 32'(err[1]), 0);
      chk("t2_rdata", 32'(rdata), 32'h3C);
      wait_idle(200);

      // Simultaneous requests, three rounds per port.
      glog.delete();
      for (int r = 0; r < 3; r++) begin
         wait_free(500);
         issue_rand(0); issue_rand(1);
         tick();
      end
      wait_idle(1000);
      chk("rr_count", glog.size(), 6);
      for (int i = 0; i < 6 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);

      // NACKed write: no write gap, queued port 1 launches two cycles after done.
      dir_q.push_back('{1, 8'h00}); dir_q.push_back('{0, 8'h77});
      issue(0, 1'b0, 1'b0, 7'h51, 16'h0022, 8'h5A);
      tick(); tick(); tick();
      issue(1, 1'b1, 1'b0, 7'h52, 16'h0033, 8'h00);
      tick();
      wait_done(0, 100);
      chk("nack_err", 32'(err[0]), 1);
      tick(); chk("nack_relaunch_c1", 32'(core_start), 0);
      tick(); chk("nack_relaunch_c2", 32'(core_start), 1);
      wait_idle(300);

      // Core never answers start.
      dir_q.push_back('{2, 8'h00});
      issue(1, 1'b0, 1'b1, 7'h53, 16'h1234, 8'hC3);
      wait_done(1, START_TO + 20);
      chk("tmo_err", 32'(err[1]), 1);
      chk("tmo_start_low", 32'(core_start), 0);
      wait_idle(200);

      // Random traffic, including ignored requests while pending.
      for (int t = 0; t < 2500; t++) begin
         tick();
         for (int p = 0; p < 2; p++) begin
            if (!has[p]) begin
               if ($urandom_range(0, 99) < 20) issue_rand(p);
            end else if (!done[p] && $urandom_range(0, 99) < 10) begin
               junk(p);
            end
         end
      end
      tick();
      wait_idle(2000);

      // Reset asserted while the core is running.
      dir_q.push_back('{3, 8'h00});
      issue(0, 1'b0, 1'b1, 7'h50, 16'h00AA, 8'h11);
      tick();
      n = 0;
      while (!core_busy && n < 50) begin tick(); n++; end
      chk("rst_run_reached", 32'(core_busy), 1);
      repeat (5) tick();
      chk("rst_in_run", 32'(busy_o && !core_start), 1);
      #2 rstn = 1'b0;
      #1 chk_all_zero("midrst");
      @(negedge clk); @(negedge clk);
      #2 rstn = 1'b1;
      tick();
      dir_q.push_back('{0, 8'h5A});
      issue(1, 1'b1, 1'b0, 7'h21, 16'h0044, 8'h00);
      tick(); chk("post_rst_c1", 32'(core_start), 0);
      tick(); chk("post_rst_c2", 32'(core_start), 1);
      wait_done(1, 100);
      chk("post_rst_err", 32'(err[1]), 0);
      chk("post_rst_rdata", 32'(rdata), 32'h5A);
      wait_idle(300);

      chk("issued_vs_done", ndone, nissue - 1);
      chk("resp_q_empty", resp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #1000000;
      nerr++; nchk++;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Shares one I2C master core between two requesters. Each requester posts a single-byte EEPROM read or write. The arbiter queues one posted request per port and grants the core round-robin. It drives the core's command inputs and handshakes with it through start/busy. After a successful write it enforces the EEPROM internal write-cycle gap before launching the next transaction. It sits between the system-side request logic and the I2C master core.

## Interface
Parameters:
- START_TO, 1000: max clk cycles `core_start` is held without `core_busy` rising before timeout.
- XFER_TO, 200000: max clk cycles `core_busy` may stay high before timeout.
- WR_WAIT_CYC, 250000: post-write idle gap in clk cycles (5 ms at 50 MHz).
- TW, 24: timer width; must hold max(START_TO, XFER_TO, WR_WAIT_CYC).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- req  in  2  per-port single-cycle request pulse.
- req_rd  in  2  per-port op: 1 = read, 0 = write.
- req_a16  in  2  per-port address mode: 1 = two-byte memory address, 0 = one-byte.
- req_dev  in  14  per-port 7-bit device address; port i uses bits [7i+6:7i].
- req_addr  in  32  per-port 16-bit memory address; port i uses [16i+15:16i].
- req_wdata  in  16  per-port write byte; port i uses [8i+7:8i].
- done  out  2  per-port one-cycle completion pulse.
- err  out  2  per-port error flag, valid only with `done`.
- rdata  out  8  last successfully read byte.
- busy_o  out  1  high whenever state is not IDLE.
- core_start  out  1  start command to the core.
- core_high_addr  out  1  address mode to the core.
- core_dev_addr  out  7  device address to the core.
- core_mem_addr  out  16  memory address to the core.
- core_rd_wr_en  out  1  1 = read, 0 = write.
- core_data_wr  out  8  write byte to the core.
- core_data_rd  in  8  read byte from the core; valid when `core_busy` falls.
- core_busy  in  1  core active (not IDLE).
- core_nack  in  1  core saw a NACK during the last transaction; valid when `core_busy` falls.

## Operation
Request capture:
- On `req[i]` with `pending[i]`=0: latch that port's fields into per-port registers and set `pending[i]`.
- `req[i]` while `pending[i]`=1 is ignored and the latched fields are unchanged.
- `req[i]` in the same cycle as `done[i]` is accepted; the set wins over the clear.

Arbitration:
- Pointer `last` resets to 1, so port 0 wins first.
- If both ports are pending, grant the port not equal to `last`.
- If one port is pending, grant it.
- On each grant, `last` := granted port.

States: IDLE, LAUNCH, RUN, COMPLETE, WR_WAIT.
- IDLE: if any `pending` and `core_busy`=0, grant a port, copy its fields to the `core_*` outputs, clear the timer, go to LAUNCH. Otherwise stay.
- LAUNCH: `core_start`=1. If `core_busy`=1, go to RUN and clear the timer. If the timer reaches START_TO-1, set `tmo`=1 and go to COMPLETE.
- RUN: `core_start`=0. If `core_busy`=0, go to COMPLETE. If the timer reaches XFER_TO-1, set `tmo`=1 and go to COMPLETE.
- COMPLETE (1 cycle):
  - `done[g]`=1 and `err[g]` = `core_nack` | `tmo`.
  - Clear `pending[g]` and `tmo`.
  - For a read without error, `rdata` := `core_data_rd`.
  - Write without error: go to WR_WAIT with the timer cleared. Otherwise go to IDLE.
- WR_WAIT: count to WR_WAIT_CYC-1, then go to IDLE. New requests are still captured.

Outputs and timer:
- `core_*` command outputs are held stable from the IDLE grant until the next grant.
- The timer saturates and never wraps.

## Timing
- Reset values: `done`, `err`, `rdata`, `busy_o`, `core_start`, all `core_*` outputs, `pending`, timer = 0. State = IDLE.
- Reset asserted mid-transaction returns everything to reset values immediately (asynchronously); `core_start` drops in the same instant.
- `core_start` rises 1 cycle after the grant edge and stays high until the cycle after `core_busy` is sampled high. The core samples start on its slow internal clock, so the hold is mandatory.
- Latency from `req` pulse to `core_start`, with the core idle and no other pending request: 2 cycles.
- `done` comes 1 cycle after `core_busy` is sampled low.
- A write-to-next-launch gap is at least WR_WAIT_CYC+1 cycles.
- A grant is never issued while `core_busy`=1, e.g. a core still stopping after a timeout.
- `done` and `err` are registered, one-cycle pulses; `err` is 0 whenever `done` is 0.

## Test plan
- Port 0 write, dev=0x50, addr=0x0010, data=0xA5, a16=1, core model acks -> `core_*` outputs match; `done[0]` pulses with `err[0]`=0; next launch no earlier than WR_WAIT_CYC cycles later.
- Port 1 read, addr=0x0010, core returns 0x3C -> `done[1]`=1, `err[1]`=0, `rdata`=0x3C.
- Both ports pulse `req` in the same cycle, each posting three successive requests -> grant order 0,1,0,1,0,1; no request lost.
- Core model asserts `core_nack` at completion of a write -> `err`=1 with `done`; no WR_WAIT (next pending request launches within 2 cycles).
- Core model never raises `core_busy` -> after START_TO cycles `done`=1, `err`=1, `core_start` drops.
- `rstn` low during RUN -> all outputs 0, `pending`=0; after release, a fresh request proceeds normally.
